// File: rtl/list_pkg.sv
// Shared types for the linked-list descriptor path: node count, pointer and
// length widths, the descriptor record and the collector FSM states.
package list_pkg;

  localparam int N     = 256;
  localparam int W_PTR = $clog2(N);
  localparam int W_LEN = W_PTR + 1;

  typedef enum logic {
    IDLE,
    ACC
  } state_e;

  typedef struct packed {
    logic [W_PTR-1:0] head;
    logic [W_PTR-1:0] tail;
    logic [W_LEN-1:0] len;
    logic [W_PTR-1:0] xsum;
    logic             sat;
  } list_desc_t;

endpackage

// File: rtl/desc_fifo.sv
// Show-ahead descriptor FIFO; a write is visible at the head one cycle later.
// No internal backpressure: the caller must gate push_i with full_o (or a same-cycle pop).
module desc_fifo
  import list_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  list_desc_t push_dat_i,
  output logic       full_o,
  input  logic       pop_i,
  output logic       empty_o,
  output list_desc_t head_dat_o
);

  localparam int AW = $clog2(DEPTH);

  list_desc_t       mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  // Extra MSB is the wrap bit that tells full from empty when indices match.
  assign full_o     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign empty_o    = (wptr_q == rptr_q);
  assign head_dat_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wptr_q[AW-1:0]] <= push_dat_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop_i) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/list_desc_collector.sv
// Folds each run of valid pointers into a head/tail/len/xsum descriptor and queues it.
// Commit reaches desc_vld one edge after the run ends; lists meeting a full FIFO are dropped.
module list_desc_collector
  import list_pkg::*;
#(
  parameter int N     = list_pkg::N,
  parameter int W_PTR = $clog2(N),
  parameter int W_LEN = W_PTR + 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_PTR-1:0] in_ptr,
  input  logic             in_ptr_vld,
  output logic [W_PTR-1:0] desc_head,
  output logic [W_PTR-1:0] desc_tail,
  output logic [W_LEN-1:0] desc_len,
  output logic [W_PTR-1:0] desc_xsum,
  output logic             desc_sat,
  output logic             desc_vld,
  input  logic             desc_rdy,
  output logic [7:0]       drop_cnt,
  output logic             busy
);

  state_e     state_q;
  list_desc_t acc_q;
  logic [7:0] drop_cnt_q;
  logic       busy_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       commit;
  logic       push;
  list_desc_t head_dat;

  assign fifo_pop = !fifo_empty && desc_rdy;
  assign commit   = (state_q == ACC) && !in_ptr_vld;
  // A pop in the same cycle frees the slot the commit needs.
  assign push     = commit && (!fifo_full || fifo_pop);

  desc_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .push_dat_i(acc_q),
    .full_o    (fifo_full),
    .pop_i     (fifo_pop),
    .empty_o   (fifo_empty),
    .head_dat_o(head_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      drop_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_ptr_vld) begin
            state_q    <= ACC;
            busy_q     <= 1'b1;
            acc_q.head <= in_ptr;
            acc_q.tail <= in_ptr;
            acc_q.xsum <= in_ptr;
            acc_q.len  <= W_LEN'(1);
            acc_q.sat  <= 1'b0;
          end
        end
        ACC: begin
          if (in_ptr_vld) begin
            acc_q.tail <= in_ptr;
            acc_q.xsum <= acc_q.xsum ^ in_ptr;
            if (&acc_q.len) begin
              acc_q.sat <= 1'b1;
            end else begin
              acc_q.len <= acc_q.len + 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!push && (drop_cnt_q != 8'hFF)) begin
              drop_cnt_q <= drop_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign desc_head = head_dat.head;
  assign desc_tail = head_dat.tail;
  assign desc_len  = head_dat.len;
  assign desc_xsum = head_dat.xsum;
  assign desc_sat  = head_dat.sat;
  assign desc_vld  = !fifo_empty;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = busy_q;

endmodule
